piso_serializer_8_bit: RTL

- Parallel-in, serial-out transmitter: the serializing end of the team's serial-in shift-register link.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock on D_out_s, with a frame-valid qualifier.
- Default order is MSB first, so an 8-bit serial-in register clocked on the same clk reconstructs the word unchanged after 8 valid cycles.

---
 rtl/piso_serializer_8_bit_if.sv | 30 +++
 rtl/piso_serializer_8_bit.sv | 100 ++++++++++
 2 files changed

// File: rtl/piso_serializer_8_bit_if.sv
// Handshake and serial-line bundle for the parallel-in, serial-out transmitter.
// master = upstream word source / line observer, slave = the serializer itself.
interface piso_serializer_8_bit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] D_in_p;
  logic             D_out_s;
  logic             D_out_valid;
  logic             last_bit;

  modport master (
    output load_valid,
    output D_in_p,
    input  load_ready,
    input  D_out_s,
    input  D_out_valid,
    input  last_bit
  );

  modport slave (
    input  load_valid,
    input  D_in_p,
    output load_ready,
    output D_out_s,
    output D_out_valid,
    output last_bit
  );
endinterface

// File: rtl/piso_serializer_8_bit.sv
// Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word on a
// valid/ready handshake and shifts it out one bit per clock, MSB first by
// default, with a frame-valid qualifier and a last-bit marker. A new word may
// be accepted during the last-bit cycle so frames run back to back.
// All outputs come from registered state only.
module piso_serializer_8_bit #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  piso_serializer_8_bit_if.slave        bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("piso_serializer_8_bit: WIDTH must be in 2..32");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic               at_last;
  logic               ready;
  logic               accept;
  logic               ser_bit;

  // Handshake and line outputs, decoded from registered state only
  always_comb begin
    at_last = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    ready   = (state_q == IDLE) || at_last;
    accept  = bus.load_valid && ready;
    ser_bit = 1'b0;
    if (state_q == SHIFT) begin
      ser_bit = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
    end
  end

  assign bus.load_ready  = ready;
  assign bus.D_out_s     = ser_bit;
  assign bus.D_out_valid = (state_q == SHIFT);
  assign bus.last_bit    = at_last;

  // Next-state, shift register and bit counter
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = bus.D_in_p;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (at_last) begin
          // Reload in the final bit cycle keeps the line gap-free
          if (accept) begin
            shreg_d = bus.D_in_p;
            cnt_d   = '0;
          end else begin
            shreg_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
